// File: rtl/zuc_eea3_if.sv
// rtl/zuc_eea3_if.sv - Signal bundle for zuc_eea3: command, payload in/out and ZUC generator link.
interface zuc_eea3_if #(
  parameter int LEN_W = 32
) ();
  logic             s_cmd_valid;
  logic             s_cmd_ready;
  logic [31:0]      s_cmd_count;
  logic [4:0]       s_cmd_bearer;
  logic             s_cmd_direction;
  logic [127:0]     s_cmd_ck;
  logic [LEN_W-1:0] s_cmd_length;

  logic             s_valid;
  logic             s_ready;
  logic [31:0]      s_data;

  logic             m_valid;
  logic             m_ready;
  logic [31:0]      m_data;
  logic             m_last;

  logic             z_valid;
  logic             z_ready;
  logic             z_init;
  logic [127:0]     z_key;
  logic [127:0]     z_iv;

  logic             k_valid;
  logic             k_ready;
  logic [31:0]      k_data;

  modport slave (
    input  s_cmd_valid, s_cmd_count, s_cmd_bearer, s_cmd_direction, s_cmd_ck, s_cmd_length,
    output s_cmd_ready,
    input  s_valid, s_data,
    output s_ready,
    output m_valid, m_data, m_last,
    input  m_ready,
    output z_valid, z_init, z_key, z_iv,
    input  z_ready,
    input  k_valid, k_data,
    output k_ready
  );

  modport master (
    output s_cmd_valid, s_cmd_count, s_cmd_bearer, s_cmd_direction, s_cmd_ck, s_cmd_length,
    input  s_cmd_ready,
    output s_valid, s_data,
    input  s_ready,
    input  m_valid, m_data, m_last,
    output m_ready,
    input  z_valid, z_init, z_key, z_iv,
    output z_ready,
    output k_valid, k_data,
    input  k_ready
  );
endinterface

// File: rtl/zuc_eea3.sv
// rtl/zuc_eea3.sv - EEA3 confidentiality wrapper: XORs payload with an external ZUC keystream.
// Optional tail masking of the final word is selected by ZUC_EEA3_TAIL_MASK_EN.
module zuc_eea3 #(
  parameter int LEN_W = 32
) (
  input  logic        clk,
  input  logic        resetn,
  zuc_eea3_if.slave   bus
);

  localparam int WL_W = LEN_W - 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       count_q, count_d;
  logic [4:0]        bearer_q, bearer_d;
  logic              dir_q, dir_d;
  logic [127:0]      ck_q, ck_d;
  logic [WL_W-1:0]   words_left_q, words_left_d;
  logic              m_valid_q, m_valid_d;
  logic [31:0]       m_data_q, m_data_d;
  logic              m_last_q, m_last_d;

  logic              cmd_ready;
  logic              cmd_fire;
  logic              pair_fire;
  logic              last_pair;
  logic [WL_W-1:0]   cmd_words;
  logic [31:0]       raw_word;
  logic [31:0]       out_word;
  logic [127:0]      key_swap;
  logic [63:0]       iv_half;

  assign cmd_words = {1'b0, bus.s_cmd_length[LEN_W-1:5]} + WL_W'(|bus.s_cmd_length[4:0]);

  assign cmd_ready = resetn && (state_q == ST_IDLE);
  assign cmd_fire  = bus.s_cmd_valid && cmd_ready;

  assign pair_fire = (state_q == ST_RUN) && bus.s_valid && bus.k_valid &&
                     (!m_valid_q || bus.m_ready) && (words_left_q != '0);
  assign last_pair = (words_left_q == WL_W'(1));

  assign raw_word = bus.s_data ^ bus.k_data;

`ifdef ZUC_EEA3_TAIL_MASK_EN
  // Number of valid bits in the final word; zero means the word is full.
  logic [4:0]  tail_q;
  logic [31:0] tail_mask;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tail_q <= 5'd0;
    end else if (cmd_fire) begin
      tail_q <= bus.s_cmd_length[4:0];
    end
  end

  assign tail_mask = ~(32'hffff_ffff >> tail_q);
  assign out_word  = (last_pair && (tail_q != 5'd0)) ? (raw_word & tail_mask) : raw_word;
`else
  assign out_word  = raw_word;
`endif

  always_comb begin
    key_swap = '0;
    for (int i = 0; i < 16; i++) begin
      key_swap[8*i +: 8] = ck_q[8*(15-i) +: 8];
    end
  end

  // Byte 0 of the IV lives in the low byte, so COUNT's MSB byte lands at [7:0].
  assign iv_half = {24'h0, bearer_q, dir_q, 2'b00,
                    count_q[7:0], count_q[15:8], count_q[23:16], count_q[31:24]};

  assign bus.s_cmd_ready = cmd_ready;
  assign bus.s_ready     = pair_fire;
  assign bus.k_ready     = pair_fire;
  assign bus.z_valid     = (state_q != ST_IDLE);
  assign bus.z_init      = (state_q == ST_INIT);
  assign bus.z_key       = key_swap;
  assign bus.z_iv        = {iv_half, iv_half};
  assign bus.m_valid     = m_valid_q;
  assign bus.m_data      = m_data_q;
  assign bus.m_last      = m_last_q;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    bearer_d     = bearer_q;
    dir_d        = dir_q;
    ck_d         = ck_q;
    words_left_d = words_left_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_last_d     = m_last_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          count_d      = bus.s_cmd_count;
          bearer_d     = bus.s_cmd_bearer;
          dir_d        = bus.s_cmd_direction;
          ck_d         = bus.s_cmd_ck;
          words_left_d = cmd_words;
          if (bus.s_cmd_length != '0) begin
            state_d = ST_INIT;
          end
        end
      end
      ST_INIT: begin
        if (bus.z_ready) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (pair_fire) begin
          words_left_d = words_left_q - WL_W'(1);
          if (last_pair) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Output register is independent of the FSM so a final word can drain after IDLE.
    if (pair_fire) begin
      m_valid_d = 1'b1;
      m_data_d  = out_word;
      m_last_d  = last_pair;
    end else if (bus.m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      bearer_q     <= '0;
      dir_q        <= 1'b0;
      ck_q         <= '0;
      words_left_q <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_last_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      bearer_q     <= bearer_d;
      dir_q        <= dir_d;
      ck_q         <= ck_d;
      words_left_q <= words_left_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_last_q     <= m_last_d;
    end
  end

endmodule

// File: tb/tb_zuc_eea3.sv
// tb/tb_zuc_eea3.sv - Randomized self-checking bench for zuc_eea3 with a mock ZUC generator.
module tb_zuc_eea3;

`ifdef ZUC_EEA3_TAIL_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  zuc_eea3_if #(.LEN_W(32)) zif ();

  zuc_eea3 #(.LEN_W(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (zif.slave)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0]  src_q[$];
  logic [31:0]  exp_q[$];
  logic         exp_last_q[$];
  logic [127:0] expkey_q[$];
  logic [127:0] expiv_q[$];

  logic         gen_on = 1'b0;
  logic [127:0] gen_key = '0;
  logic [127:0] gen_iv = '0;
  int           ks_idx = 0;
  int           pct_s = 100, pct_k = 100, pct_m = 100, pct_z = 100;
  int           out_cnt = 0;
  int           init_cycles = 0;
  logic         prev_stall = 1'b0;
  logic [31:0]  prev_data = '0;
  logic         prev_last = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit rnd(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  // Stand-in keystream: true ZUC output for the all-zero key/IV, a keyed hash otherwise.
  function automatic logic [31:0] ks_word(input logic [127:0] k, input logic [127:0] v, input int i);
    logic [31:0] h;
    if (k == '0 && v == '0 && i < 2) return (i == 0) ? 32'h27bede74 : 32'h018082da;
    h = k[31:0] ^ {k[62:32], k[63]} ^ {k[93:64], k[95:94]} ^ {k[124:96], k[127:125]}
        ^ v[31:0] ^ {v[55:32], v[63:56]} ^ {v[79:64], v[95:80]} ^ {v[103:96], v[127:104]}
        ^ (32'(i) * 32'h9e3779b9);
    h = h ^ (h >> 15);
    h = h * 32'h2c1b3c6d;
    h = h ^ (h >> 12);
    return h;
  endfunction

  // Single process playing payload source, ZUC generator and output sink.
  initial begin
    logic z_hs, k_hs, s_hs, m_hs;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        src_q.delete(); exp_q.delete(); exp_last_q.delete();
        expkey_q.delete(); expiv_q.delete();
        gen_on = 1'b0;
        prev_stall = 1'b0;
      end else begin
        z_hs = zif.z_valid && zif.z_ready && zif.z_init;
        k_hs = zif.k_valid && zif.k_ready;
        s_hs = zif.s_valid && zif.s_ready;
        m_hs = zif.m_valid && zif.m_ready;
        if (zif.z_init) init_cycles++;
        if (prev_stall) begin
          check("hold_valid", zif.m_valid, 1'b1);
          check("hold_data", zif.m_data, prev_data);
          check("hold_last", zif.m_last, prev_last);
        end
        prev_stall = zif.m_valid && !zif.m_ready;
        prev_data  = zif.m_data;
        prev_last  = zif.m_last;
        check("pair_together", zif.s_ready, zif.k_ready);
        if (m_hs) begin
          out_cnt++;
          check("word_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            check($sformatf("m_data#%0d", out_cnt), zif.m_data, exp_q.pop_front());
            check($sformatf("m_last#%0d", out_cnt), zif.m_last, exp_last_q.pop_front());
          end
        end
        if (z_hs) begin
          check("init_expected", expkey_q.size() != 0, 1'b1);
          if (expkey_q.size() != 0) begin
            check("z_key", zif.z_key, expkey_q.pop_front());
            check("z_iv", zif.z_iv, expiv_q.pop_front());
          end
          gen_key = zif.z_key;
          gen_iv  = zif.z_iv;
          gen_on  = 1'b1;
          ks_idx  = 0;
        end
        if (k_hs) ks_idx++;
        if (s_hs && src_q.size() != 0) void'(src_q.pop_front());
      end
      @(posedge clk);
      #1;
      zif.s_valid = (src_q.size() != 0) && rnd(pct_s);
      zif.s_data  = (src_q.size() != 0) ? src_q[0] : $urandom;
      zif.k_valid = gen_on && rnd(pct_k);
      zif.k_data  = ks_word(gen_key, gen_iv, ks_idx);
      zif.z_ready = rnd(pct_z);
      zif.m_ready = rnd(pct_m);
    end
  end

  // pmode: 0 = zeros, 1 = all ones, 2 = random payload.
  task automatic send_cmd(input logic [31:0] count, input logic [4:0] bearer, input logic dir,
                          input logic [127:0] ck, input int len, input int pmode);
    logic [127:0] ek, ev;
    logic [7:0]   ivb[16];
    logic [31:0]  p, w;
    int n, r;
    bit ok;
    for (int i = 0; i < 16; i++) ek[8*i +: 8] = ck[8*(15-i) +: 8];
    ivb[0] = count[31:24]; ivb[1] = count[23:16]; ivb[2] = count[15:8]; ivb[3] = count[7:0];
    ivb[4] = {bearer, dir, 2'b00};
    ivb[5] = 8'h0; ivb[6] = 8'h0; ivb[7] = 8'h0;
    for (int i = 0; i < 8; i++) ivb[8+i] = ivb[i];
    for (int i = 0; i < 16; i++) ev[8*i +: 8] = ivb[i];
    n = (len + 31) / 32;
    r = len % 32;
    if (n != 0) begin
      expkey_q.push_back(ek);
      expiv_q.push_back(ev);
    end
    for (int i = 0; i < n; i++) begin
      p = (pmode == 0) ? 32'h0 : (pmode == 1) ? 32'hffffffff : $urandom;
      src_q.push_back(p);
      w = p ^ ks_word(ek, ev, i);
      if (i == n - 1 && r != 0 && MASK_EN)
        for (int b = 0; b < 32 - r; b++) w[b] = 1'b0;
      exp_q.push_back(w);
      exp_last_q.push_back(i == n - 1);
    end
    zif.s_cmd_count = count;
    zif.s_cmd_bearer = bearer;
    zif.s_cmd_direction = dir;
    zif.s_cmd_ck = ck;
    zif.s_cmd_length = 32'(len);
    zif.s_cmd_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 3000 && !ok; c++) begin
      @(negedge clk);
      ok = zif.s_cmd_ready;
    end
    check("cmd_accept", ok, 1'b1);
    @(posedge clk);
    #1;
    zif.s_cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int c = 0; c < 20000; c++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0 && src_q.size() == 0) break;
    end
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    int base_out, base_init;
    bit seen;
    resetn = 1'b0;
    zif.s_cmd_valid = 1'b0; zif.s_cmd_count = '0; zif.s_cmd_bearer = '0;
    zif.s_cmd_direction = 1'b0; zif.s_cmd_ck = '0; zif.s_cmd_length = '0;
    zif.s_valid = 1'b0; zif.s_data = '0; zif.m_ready = 1'b0;
    zif.z_ready = 1'b0; zif.k_valid = 1'b0; zif.k_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", zif.s_cmd_ready, 1'b0);
    check("rst_s_ready", zif.s_ready, 1'b0);
    check("rst_k_ready", zif.k_ready, 1'b0);
    check("rst_z_valid", zif.z_valid, 1'b0);
    check("rst_z_init", zif.z_init, 1'b0);
    check("rst_m_valid", zif.m_valid, 1'b0);
    check("rst_m_data", zif.m_data, 32'h0);
    check("rst_m_last", zif.m_last, 1'b0);
    #3 resetn = 1'b1;
    @(posedge clk);
    #1;
    check("idle_cmd_ready", zif.s_cmd_ready, 1'b1);

    send_cmd(32'h0, 5'd0, 1'b0, 128'h0, 64, 0);
    wait_done("drain_len64");
    send_cmd(32'h0, 5'd0, 1'b0, 128'h0, 40, 0);
    wait_done("drain_len40");
    send_cmd(32'h0, 5'd0, 1'b0, 128'h0, 32, 1);
    wait_done("drain_len32");

    pct_s = 50; pct_k = 60; pct_m = 40; pct_z = 50;
    send_cmd(32'h0, 5'd0, 1'b0, 128'h0, 64, 0);
    wait_done("drain_stall64");

    base_out = out_cnt;
    base_init = init_cycles;
    send_cmd(32'h0, 5'd0, 1'b0, 128'h0, 0, 0);
    check("len0_cmd_ready", zif.s_cmd_ready, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    check("len0_no_init", init_cycles, base_init);
    check("len0_no_output", out_cnt, base_out);

    pct_s = 70; pct_k = 60; pct_m = 50; pct_z = 50;
    for (int t = 0; t < 10; t++) begin
      send_cmd($urandom, 5'($urandom), 1'($urandom),
               {$urandom, $urandom, $urandom, $urandom}, $urandom_range(1, 200), 2);
    end
    wait_done("drain_random");

    pct_s = 100; pct_k = 100; pct_m = 100; pct_z = 100;
    base_out = out_cnt;
    send_cmd(32'h0, 5'd0, 1'b0, 128'h0, 64, 0);
    seen = 1'b0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(posedge clk);
      #2;
      seen = (out_cnt > base_out);
    end
    check("first_word_seen", seen, 1'b1);
    resetn = 1'b0;
    #1;
    check("midrst_m_valid", zif.m_valid, 1'b0);
    check("midrst_cmd_ready", zif.s_cmd_ready, 1'b0);
    check("midrst_z_valid", zif.z_valid, 1'b0);
    check("midrst_s_ready", zif.s_ready, 1'b0);
    repeat (3) @(posedge clk);
    #3 resetn = 1'b1;
    send_cmd(32'h0, 5'd0, 1'b0, 128'h0, 64, 0);
    wait_done("drain_after_rst");
    repeat (5) @(posedge clk);
    #1;
    check("final_m_valid", zif.m_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
